// File: rtl/muxn_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready on every input and on the output.
// Define MUXN_RR_EN to build the round-robin arbiter (mode_i=1); otherwise mode_i is ignored.
module muxn_reg #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]   in_valid_i,
  output logic [N-1:0]   in_ready_o,
  input  logic [SW-1:0]  sel_i,
  input  logic           mode_i,
  output logic [W-1:0]   out_data_o,
  output logic [SW-1:0]  out_ch_o,
  output logic           out_valid_o,
  input  logic           out_ready_i
);

  logic          load_ok;
  logic          gnt;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_ch_q;

`ifdef MUXN_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rr_rot;
  logic [SW-1:0] rr_off;
  logic [SW:0]   rr_sum;
`else
  logic          unused_mode;
  assign unused_mode = mode_i;
`endif

  assign load_ok = !out_valid_q || out_ready_i;

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    // Direct select; an out-of-range sel_i matches no channel and yields no grant.
    for (int k = 0; k < int'(N); k++) begin
      if (sel_i == SW'(k) && in_valid_i[k]) begin
        gnt     = 1'b1;
        gnt_idx = SW'(k);
      end
    end
`ifdef MUXN_RR_EN
    rr_rot = N'({in_valid_i, in_valid_i} >> ptr_q);
    rr_off = '0;
    rr_sum = '0;
    if (mode_i) begin
      gnt = 1'b0;
      // Rotated so bit 0 is the channel at ptr; the lowest set bit wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (rr_rot[i]) begin
          gnt    = 1'b1;
          rr_off = SW'(i);
        end
      end
      rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
      if (rr_sum >= (SW+1)'(N)) rr_sum = rr_sum - (SW+1)'(N);
      gnt_idx = rr_sum[SW-1:0];
    end
`endif
  end

  always_comb begin
    gnt_data   = '0;
    in_ready_o = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (gnt_idx == SW'(k)) begin
        gnt_data      = in_data_i[k*W +: W];
        in_ready_o[k] = gnt && load_ok && !rst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (load_ok) begin
      out_valid_q <= gnt;
      if (gnt) begin
        out_data_q <= gnt_data;
        out_ch_q   <= gnt_idx;
      end
    end
  end

`ifdef MUXN_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (mode_i && gnt && load_ok) begin
      ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule
